efpga_xcel_ctrl: RTL and testbench

Parametrised controller between the core's custom-instruction path and the eFPGA fabric. It generalises the fixed two-operand, three-result, done-only link. It accepts one request per valid/ready handshake and drives N operands, operator and delay to the fabric with a one-cycle write strobe. Completion is either a programmed fixed delay or the fabric's done signal, with a timeout. It returns a selected result (plus all results) over a valid/ready response channel.

---
 rtl/efpga_xcel_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_efpga_xcel_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/efpga_xcel_ctrl.sv
// Custom-instruction accelerator controller for the eFPGA fabric: accepts one request,
// launches it with a write strobe, waits a fixed delay or for done/timeout, then returns results.
module efpga_xcel_ctrl #(
  parameter int DataWidth     = 32,
  parameter int NumOperands   = 2,
  parameter int NumResults    = 3,
  parameter int OpWidth       = 2,
  parameter int DelayWidth    = 4,
  parameter int TimeoutCycles = 255,
  parameter int SelWidth      = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_mode_i,
  input  logic [OpWidth-1:0]                req_operator_i,
  input  logic [DelayWidth-1:0]             req_delay_i,
  input  logic [SelWidth-1:0]               req_sel_i,
  input  logic [NumOperands*DataWidth-1:0]  req_operands_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [DataWidth-1:0]              resp_result_o,
  output logic [NumResults*DataWidth-1:0]   resp_all_o,
  output logic                              resp_timeout_o,
  output logic                              resp_err_o,
  output logic                              busy_o,
  output logic [NumOperands*DataWidth-1:0]  efpga_operands_o,
  output logic [OpWidth-1:0]                efpga_operator_o,
  output logic [DelayWidth-1:0]             efpga_delay_o,
  output logic                              efpga_write_strobe_o,
  output logic                              efpga_en_o,
  input  logic [NumResults*DataWidth-1:0]   efpga_results_i,
  input  logic                              efpga_done_i
);

  localparam int TimeoutBits = $clog2(TimeoutCycles + 1);
  localparam int CntWidth    = (DelayWidth > TimeoutBits) ? DelayWidth : TimeoutBits;
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                              state_r;
  logic                                mode_r;
  logic [SelWidth-1:0]                 sel_r;
  logic [CntWidth-1:0]                 cnt_r;
  logic [NumOperands*DataWidth-1:0]    operands_r;
  logic [OpWidth-1:0]                  operator_r;
  logic [DelayWidth-1:0]               delay_r;
  logic                                strobe_r;
  logic                                en_r;
  logic                                req_ready_r;
  logic                                busy_r;
  logic                                resp_valid_r;
  logic [DataWidth-1:0]                resp_result_r;
  logic [NumResults*DataWidth-1:0]     resp_all_r;
  logic                                timeout_r;
  logic                                err_r;
  logic                                capture_s;
  logic                                timeout_hit_s;

  // Out-of-range selects return zero rather than indexing past the result vector.
  function automatic logic [DataWidth-1:0] sel_result(
    input logic [NumResults*DataWidth-1:0] all,
    input logic [SelWidth-1:0]             sel
  );
    logic [DataWidth-1:0] res;
    res = '0;
    for (int k = 0; k < NumResults; k++) begin
      if (sel == SelWidth'(k)) begin
        res = all[k*DataWidth +: DataWidth];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic sel_in_range(input logic [SelWidth-1:0] sel);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NumResults; k++) begin
      if (sel == SelWidth'(k)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Completion decision for the current WAIT cycle.
  always_comb begin
    capture_s     = 1'b0;
    timeout_hit_s = 1'b0;
    if (state_r != WAIT) begin
      capture_s = 1'b0;
    end else if (!mode_r) begin
      capture_s = (cnt_r == '0);
    end else if (efpga_done_i) begin
      capture_s = 1'b1;
    end else if (cnt_r == TimeoutLast) begin
      capture_s     = 1'b1;
      timeout_hit_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Controller FSM; every output flag is registered alongside the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      mode_r        <= 1'b0;
      sel_r         <= '0;
      cnt_r         <= '0;
      operands_r    <= '0;
      operator_r    <= '0;
      delay_r       <= '0;
      strobe_r      <= 1'b0;
      en_r          <= 1'b0;
      req_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_result_r <= '0;
      resp_all_r    <= '0;
      timeout_r     <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            mode_r      <= req_mode_i;
            sel_r       <= req_sel_i;
            operands_r  <= req_operands_i;
            operator_r  <= req_operator_i;
            delay_r     <= req_delay_i;
            strobe_r    <= 1'b1;
            en_r        <= 1'b1;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= STROBE;
          end else begin
            state_r <= IDLE;
          end
        end
        STROBE: begin
          strobe_r <= 1'b0;
          cnt_r    <= mode_r ? '0 : CntWidth'(delay_r);
          state_r  <= WAIT;
        end
        WAIT: begin
          if (capture_s) begin
            resp_all_r    <= efpga_results_i;
            resp_result_r <= sel_result(efpga_results_i, sel_r);
            err_r         <= ~sel_in_range(sel_r);
            timeout_r     <= timeout_hit_s;
            resp_valid_r  <= 1'b1;
            en_r          <= 1'b0;
            state_r       <= RESP;
          end else if (mode_r) begin
            cnt_r <= cnt_r + CntWidth'(1);
          end else begin
            cnt_r <= cnt_r - CntWidth'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          strobe_r     <= 1'b0;
          en_r         <= 1'b0;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o          = req_ready_r;
  assign busy_o               = busy_r;
  assign resp_valid_o         = resp_valid_r;
  assign resp_result_o        = resp_result_r;
  assign resp_all_o           = resp_all_r;
  assign resp_timeout_o       = timeout_r;
  assign resp_err_o           = err_r;
  assign efpga_operands_o     = operands_r;
  assign efpga_operator_o     = operator_r;
  assign efpga_delay_o        = delay_r;
  assign efpga_write_strobe_o = strobe_r;
  assign efpga_en_o           = en_r;

endmodule

// File: tb/tb_efpga_xcel_ctrl.sv
// Table-driven bench for efpga_xcel_ctrl plus directed backpressure and reset-abort sequences.
module tb_efpga_xcel_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_mode_i;
  logic [1:0]  req_operator_i;
  logic [3:0]  req_delay_i;
  logic [1:0]  req_sel_i;
  logic [63:0] req_operands_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_result_o;
  logic [95:0] resp_all_o;
  logic        resp_timeout_o;
  logic        resp_err_o;
  logic        busy_o;
  logic [63:0] efpga_operands_o;
  logic [1:0]  efpga_operator_o;
  logic [3:0]  efpga_delay_o;
  logic        efpga_write_strobe_o;
  logic        efpga_en_o;
  logic [95:0] efpga_results_i;
  logic        efpga_done_i;

  int checks = 0;
  int errors = 0;

  efpga_xcel_ctrl #(
    .DataWidth(32), .NumOperands(2), .NumResults(3), .OpWidth(2),
    .DelayWidth(4), .TimeoutCycles(8), .SelWidth(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mode_i(req_mode_i),
    .req_operator_i(req_operator_i), .req_delay_i(req_delay_i), .req_sel_i(req_sel_i),
    .req_operands_i(req_operands_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_result_o(resp_result_o),
    .resp_all_o(resp_all_o), .resp_timeout_o(resp_timeout_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .efpga_operands_o(efpga_operands_o), .efpga_operator_o(efpga_operator_o),
    .efpga_delay_o(efpga_delay_o), .efpga_write_strobe_o(efpga_write_strobe_o),
    .efpga_en_o(efpga_en_o), .efpga_results_i(efpga_results_i), .efpga_done_i(efpga_done_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        mode;
    logic [3:0]  delay;
    logic [1:0]  sel;
    logic [1:0]  op;
    logic [63:0] ops;
    logic [95:0] base;
    logic        vary;
    int          done_a;
    int          done_b;
    int          lat;
    logic [31:0] exp_res;
    logic [95:0] exp_all;
    logic        exp_to;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Fabric model: each lane is its base value, optionally plus the current cycle number.
  function automatic logic [95:0] fab(input logic [95:0] base, input logic vary, input int c);
    logic [95:0] r;
    for (int j = 0; j < 3; j++) begin
      r[j*32 +: 32] = base[j*32 +: 32] + (vary ? 32'(c) : 32'd0);
    end
    return r;
  endfunction

  initial begin
    vec_t v;
    int   c;
    bit   seen;

    //          mode  D      sel    op     operands                  fabric base                                   vary  dA  dB  lat result        all                                          to    err
    vecs[0] = '{1'b0, 4'd3,  2'd1, 2'd2, 64'h9ABCDEF0_12345678, 96'h00000033_00000022_00000011, 1'b0, -1, -1, 6,  32'h00000022, 96'h00000033_00000022_00000011, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd5,  2'd0, 2'd1, 64'h00000002_00000001, 96'h00003000_00002000_00001000, 1'b1,  1,  7, 8,  32'h00001007, 96'h00003007_00002007_00001007, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'd0,  2'd2, 2'd3, 64'hCAFEBABE_DEADBEEF, 96'h00000300_00000200_00000100, 1'b1, -1, -1, 10, 32'h00000309, 96'h00000309_00000209_00000109, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 4'd0,  2'd3, 2'd0, 64'h11111111_22222222, 96'h00000066_00000055_00000044, 1'b0, -1, -1, 3,  32'h00000000, 96'h00000066_00000055_00000044, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'd15, 2'd2, 2'd1, 64'h33333333_44444444, 96'h00007000_00006000_00005000, 1'b1, -1, -1, 18, 32'h00007011, 96'h00007011_00006011_00005011, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'd2,  2'd0, 2'd2, 64'h55555555_66666666, 96'hDEAD0003_DEAD0002_DEAD0001, 1'b0,  2,  3, 5,  32'hDEAD0001, 96'hDEAD0003_DEAD0002_DEAD0001, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 4'd9,  2'd1, 2'd3, 64'h77777777_88888888, 96'h00000030_00000020_00000010, 1'b1,  2, -1, 3,  32'h00000022, 96'h00000032_00000022_00000012, 1'b0, 1'b0};

    rst_i = 1'b1; req_valid_i = 1'b0; req_mode_i = 1'b0; req_operator_i = 2'd0;
    req_delay_i = 4'd0; req_sel_i = 2'd0; req_operands_i = 64'd0; resp_ready_i = 1'b0;
    efpga_results_i = 96'd0; efpga_done_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;

    chk("rst_req_ready", 128'(req_ready_o), 128'(1'b1));
    chk("rst_busy", 128'(busy_o), 128'(1'b0));
    chk("rst_resp_valid", 128'(resp_valid_o), 128'(1'b0));
    chk("rst_resp_result", 128'(resp_result_o), 128'(32'd0));
    chk("rst_resp_all", 128'(resp_all_o), 128'(96'd0));
    chk("rst_flags", 128'({resp_timeout_o, resp_err_o, efpga_write_strobe_o, efpga_en_o}), 128'(4'd0));
    chk("rst_efpga_regs", 128'({efpga_operands_o, efpga_operator_o, efpga_delay_o}), 128'(70'd0));

    // Table-driven transactions: acceptance is cycle 0, response latency measured in cycles.
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      req_valid_i = 1'b1; req_mode_i = v.mode; req_delay_i = v.delay; req_sel_i = v.sel;
      req_operator_i = v.op; req_operands_i = v.ops;
      efpga_results_i = fab(v.base, v.vary, 0);
      efpga_done_i = 1'b0;
      chk($sformatf("v%0d_ready_idle", i), 128'(req_ready_o), 128'(1'b1));
      c = 0;
      seen = 1'b0;
      while (!seen && c < 60) begin
        step();
        c++;
        if (c == 1) req_valid_i = 1'b0;
        efpga_results_i = fab(v.base, v.vary, c);
        efpga_done_i = (c == v.done_a) || (c == v.done_b);
        chk($sformatf("v%0d_c%0d_strobe", i, c), 128'(efpga_write_strobe_o), 128'(c == 1));
        chk($sformatf("v%0d_c%0d_en", i, c), 128'(efpga_en_o), 128'(c < v.lat));
        chk($sformatf("v%0d_c%0d_busy_ready", i, c), 128'({busy_o, req_ready_o}), 128'(2'b10));
        chk($sformatf("v%0d_c%0d_resp_valid", i, c), 128'(resp_valid_o), 128'(c >= v.lat));
        if (c == 1) begin
          chk($sformatf("v%0d_latched", i), 128'({efpga_operands_o, efpga_operator_o, efpga_delay_o}),
              128'({v.ops, v.op, v.delay}));
        end
        if (resp_valid_o) seen = 1'b1;
      end
      chk($sformatf("v%0d_latency", i), 128'(c), 128'(v.lat));
      chk($sformatf("v%0d_result", i), 128'(resp_result_o), 128'(v.exp_res));
      chk($sformatf("v%0d_all", i), 128'(resp_all_o), 128'(v.exp_all));
      chk($sformatf("v%0d_timeout", i), 128'(resp_timeout_o), 128'(v.exp_to));
      chk($sformatf("v%0d_err", i), 128'(resp_err_o), 128'(v.exp_err));
      resp_ready_i = 1'b1;
      efpga_done_i = 1'b0;
      step();
      resp_ready_i = 1'b0;
      chk($sformatf("v%0d_after_hs", i), 128'({resp_valid_o, req_ready_o, busy_o}), 128'(3'b010));
    end

    // Backpressure: response held 10 cycles while fabric moves and a second request waits.
    req_valid_i = 1'b1; req_mode_i = 1'b0; req_delay_i = 4'd0; req_sel_i = 2'd0;
    req_operator_i = 2'd1; req_operands_i = 64'hAAAA0001_AAAA0000;
    efpga_results_i = fab(96'h000000C0_000000B0_000000A0, 1'b1, 0);
    for (int cc = 1; cc <= 13; cc++) begin
      step();
      if (cc == 1) req_operands_i = 64'hBBBB0001_BBBB0000;
      efpga_results_i = fab(96'h000000C0_000000B0_000000A0, 1'b1, cc);
      if (cc >= 3) begin
        chk($sformatf("bp_c%0d_valid", cc), 128'(resp_valid_o), 128'(1'b1));
        chk($sformatf("bp_c%0d_result", cc), 128'(resp_result_o), 128'(32'h000000A2));
        chk($sformatf("bp_c%0d_all", cc), 128'(resp_all_o), 128'(96'h000000C2_000000B2_000000A2));
        chk($sformatf("bp_c%0d_ready", cc), 128'(req_ready_o), 128'(1'b0));
        chk($sformatf("bp_c%0d_ops_hold", cc), 128'(efpga_operands_o), 128'(64'hAAAA0001_AAAA0000));
      end
    end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    chk("bp_idle_ready", 128'({req_ready_o, resp_valid_o, efpga_write_strobe_o}), 128'(3'b100));
    step();
    req_valid_i = 1'b0;
    chk("bp_second_strobe", 128'(efpga_write_strobe_o), 128'(1'b1));
    chk("bp_second_ops", 128'(efpga_operands_o), 128'(64'hBBBB0001_BBBB0000));
    c = 0;
    while (!resp_valid_o && c < 20) begin
      step();
      c++;
    end
    chk("bp_second_latency", 128'(c), 128'(2));
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;

    // Reset abort in the third WAIT cycle of a done-mode operation.
    req_valid_i = 1'b1; req_mode_i = 1'b1; req_sel_i = 2'd1; req_operands_i = 64'h12121212_34343434;
    efpga_results_i = 96'h3_00000002_00000001;
    for (int cc = 1; cc <= 4; cc++) begin
      step();
      req_valid_i = 1'b0;
    end
    chk("rs_in_wait", 128'({busy_o, efpga_en_o}), 128'(2'b11));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rs_flags", 128'({efpga_en_o, efpga_write_strobe_o, busy_o, resp_valid_o}), 128'(4'd0));
    chk("rs_ready", 128'(req_ready_o), 128'(1'b1));
    chk("rs_ops_cleared", 128'(efpga_operands_o), 128'(64'd0));
    efpga_done_i = 1'b1;
    step();
    efpga_done_i = 1'b0;
    seen = 1'b0;
    for (int cc = 0; cc < 15; cc++) begin
      if (resp_valid_o || busy_o) seen = 1'b1;
      step();
    end
    chk("rs_no_response", 128'(seen), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
